// File: rtl/seven_seg_scan_pkg.sv
// rtl/seven_seg_scan_pkg.sv - register map, CTRL fields and hex segment table for the scanned display
package seven_seg_scan_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_HEX    = 3'd1;
  localparam logic [2:0] ADDR_RAW_LO = 3'd2;
  localparam logic [2:0] ADDR_RAW_HI = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_DECODE    = 1;
  localparam int CTRL_BLINK_LSB = 8;

  // Active-high gfedcba patterns, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seven_seg_scan_pio_if.sv
// rtl/seven_seg_scan_pio_if.sv - zero-wait-state register slave bus for the scanned display
interface seven_seg_scan_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/seven_seg_hex_decoder.sv
// rtl/seven_seg_hex_decoder.sv - 4-bit value to active-high gfedcba segment pattern
module seven_seg_hex_decoder
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_pio.sv
// rtl/seven_seg_scan_pio.sv - multi-digit time-multiplexed seven-segment register slave
module seven_seg_scan_pio
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 64,
  parameter int BLINK_FRAMES   = 250,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seven_seg_scan_pio_if.slave   bus,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0]  DIG_MASK = 8'((16'd1 << NUM_DIGITS) - 16'd1);
  localparam logic [31:0] HEX_MASK = 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
  localparam logic [6:0]  SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic        enable, decode;
  logic [7:0]  blink_mask;
  logic [31:0] hex;
  logic [6:0]  raw [8];

  logic        enable_nxt, decode_nxt;
  logic [7:0]  mask_nxt;
  logic [31:0] hex_nxt;
  logic [6:0]  raw_nxt [8];

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic wr;
  assign wr = bus.chipselect && !bus.write_n;

  // Next register values double as a write bypass so a write reaches the pins one cycle later.
  always_comb begin
    enable_nxt = enable;
    decode_nxt = decode;
    mask_nxt   = blink_mask;
    hex_nxt    = hex;
    for (int i = 0; i < 8; i++) raw_nxt[i] = raw[i];
    if (wr) begin
      case (bus.address)
        ADDR_CTRL: begin
          enable_nxt = bus.writedata[CTRL_ENABLE];
          decode_nxt = bus.writedata[CTRL_DECODE];
          mask_nxt   = bus.writedata[CTRL_BLINK_LSB +: 8] & DIG_MASK;
        end
        ADDR_HEX: hex_nxt = bus.writedata & HEX_MASK;
        ADDR_RAW_LO: begin
          for (int i = 0; i < 4; i++)
            if (DIG_MASK[i]) raw_nxt[i] = bus.writedata[8*i +: 7];
        end
        ADDR_RAW_HI: begin
          for (int i = 0; i < 4; i++)
            if (DIG_MASK[i+4]) raw_nxt[i+4] = bus.writedata[8*i +: 7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable     <= 1'b0;
      decode     <= 1'b0;
      blink_mask <= '0;
      hex        <= '0;
      for (int i = 0; i < 8; i++) raw[i] <= '0;
    end else begin
      enable     <= enable_nxt;
      decode     <= decode_nxt;
      blink_mask <= mask_nxt;
      hex        <= hex_nxt;
      for (int i = 0; i < 8; i++) raw[i] <= raw_nxt[i];
    end
  end

  // A same-cycle disable wins over a prescaler wrap because enable_nxt already reflects it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!enable_nxt) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      if (idx == 3'(NUM_DIGITS - 1)) begin
        idx <= '0;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else begin
        idx <= idx + 3'd1;
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic                  slot_active;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] sel_hi;

  assign nibble = hex_nxt[{idx, 2'b00} +: 4];

  seven_seg_hex_decoder u_hex_decoder (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    slot_active = enable_nxt && (presc >= PW'(BLANK_CYCLES));
    seg_hi      = decode_nxt ? dec_seg : raw_nxt[idx];
    if (!slot_active || (mask_nxt[idx] && blink_phase)) seg_hi = '0;
    sel_hi = slot_active ? (NUM_DIGITS'(1) << idx) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out   <= SEG_OFF;
      digit_sel <= DIG_OFF;
    end else begin
      seg_out   <= (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
      digit_sel <= (DIG_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
    end
  end

  logic [31:0] rd;
  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_CTRL: begin
        rd[CTRL_ENABLE]               = enable;
        rd[CTRL_DECODE]               = decode;
        rd[CTRL_BLINK_LSB +: 8]       = blink_mask;
      end
      ADDR_HEX:    rd = hex;
      ADDR_RAW_LO: for (int i = 0; i < 4; i++) rd[8*i +: 7] = raw[i];
      ADDR_RAW_HI: for (int i = 0; i < 4; i++) rd[8*i +: 7] = raw[i+4];
      ADDR_STATUS: begin
        rd[2:0] = idx;
        rd[8]   = blink_phase;
        rd[9]   = enable && (presc < PW'(BLANK_CYCLES));
      end
      default: ;
    endcase
  end
  assign bus.readdata = rd;

endmodule

// File: tb/tb_seven_seg_scan_pio.sv
// tb/tb_seven_seg_scan_pio.sv - directed self-checking bench for seven_seg_scan_pio
module tb_seven_seg_scan_pio;

  logic       clk;
  logic       reset_n;
  logic [6:0] seg_out;
  logic [3:0] digit_sel;
  int         n_checks;
  int         n_errors;

  seven_seg_scan_pio_if bus_if ();

  seven_seg_scan_pio #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .BLANK_CYCLES   (1),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .seg_out   (seg_out),
    .digit_sel (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    #1;
    check(tag, bus_if.readdata, exp);
    bus_if.chipselect = 1'b0;
  endtask

  // Returns at the negedge of the first active cycle of the slot whose select is 'target'.
  task automatic wait_slot(input string tag, input logic [3:0] target);
    logic [3:0] prev;
    bit         found;
    prev  = digit_sel;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (prev == 4'hF && digit_sel == target) found = 1'b1;
      prev = digit_sel;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Starting at the first active cycle of digit 0: 3 active cycles then 1 blank per digit.
  task automatic check_frame(input string tag, input logic [3:0][6:0] exp_seg);
    for (int c = 0; c < 16; c++) begin
      int d;
      if (c > 0) @(negedge clk);
      d = c / 4;
      if (c % 4 == 3) begin
        check($sformatf("%s_sel_c%0d", tag, c), 32'(digit_sel), 32'hF);
        check($sformatf("%s_seg_c%0d", tag, c), 32'(seg_out), 32'h7F);
      end else begin
        check($sformatf("%s_sel_c%0d", tag, c), 32'(digit_sel), 32'(~(4'b0001 << d) & 4'hF));
        check($sformatf("%s_seg_c%0d", tag, c), 32'(seg_out), 32'(exp_seg[d]));
      end
    end
  endtask

  initial begin
    logic       phase, last_phase;
    int         since, toggles, lit_seen, dark_seen;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    check("idle_seg", 32'(seg_out), 32'h7F);
    check("idle_sel", 32'(digit_sel), 32'hF);
    for (int a = 0; a < 8; a++) read_check($sformatf("idle_rd%0d", a), 3'(a), 32'd0);

    for (int a = 5; a < 8; a++) bus_write(3'(a), 32'hFFFF_FFFF);
    for (int a = 0; a < 5; a++) read_check($sformatf("ignored_wr_rd%0d", a), 3'(a), 32'd0);
    check("ignored_wr_sel", 32'(digit_sel), 32'hF);

    // Hex decode of A5C3
    bus_write(3'd1, 32'h0000_A5C3);
    bus_write(3'd0, 32'h0000_0003);
    wait_slot("sync_hex", 4'hE);
    check_frame("hex", {7'h08, 7'h12, 7'h46, 7'h30});
    read_check("rd_ctrl_hex", 3'd0, 32'h0000_0003);

    // Raw segments
    bus_write(3'd0, 32'h0000_0001);
    bus_write(3'd2, 32'h4000_0601);
    wait_slot("sync_raw", 4'hE);
    check_frame("raw", {7'h3F, 7'h7F, 7'h79, 7'h7E});
    read_check("rd_raw_lo", 3'd2, 32'h4000_0601);
    read_check("rd_hex_kept", 3'd1, 32'h0000_A5C3);
    read_check("rd_raw_hi", 3'd3, 32'h0000_0000);

    // Blink digit 1
    bus_write(3'd0, 32'h0000_0203);
    read_check("rd_ctrl_blink", 3'd0, 32'h0000_0203);
    bus_if.address = 3'd4;
    @(negedge clk);
    #1;
    last_phase = bus_if.readdata[8];
    since = 0; toggles = 0; lit_seen = 0; dark_seen = 0;
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      #1;
      phase = bus_if.readdata[8];
      since++;
      if (phase != last_phase) begin
        if (toggles > 0) check("blink_period", 32'(since), 32'd32);
        toggles++;
        since = 0;
      end
      last_phase = phase;
      if (digit_sel == 4'hD) begin
        check("blink_d1", 32'(seg_out), phase ? 32'h7F : 32'h46);
        if (seg_out == 7'h46) lit_seen++;
        if (seg_out == 7'h7F) dark_seen++;
      end
      if (digit_sel == 4'hE) check("blink_d0", 32'(seg_out), 32'h30);
      if (digit_sel == 4'h7) check("blink_d3", 32'(seg_out), 32'h08);
    end
    check("blink_toggles", 32'(toggles >= 3), 32'd1);
    check("blink_lit_seen", 32'(lit_seen > 0), 32'd1);
    check("blink_dark_seen", 32'(dark_seen > 0), 32'd1);

    // Mid-slot HEX rewrite of digit 2
    wait_slot("sync_d2", 4'hB);
    @(negedge clk);
    bus_if.address    = 3'd1;
    bus_if.writedata  = 32'h0000_A8C3;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    check("midwr_seg_before", 32'(seg_out), 32'h12);
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    check("midwr_seg_after", 32'(seg_out), 32'h00);
    check("midwr_sel_after", 32'(digit_sel), 32'hB);

    // Mid-slot disable, then re-enable
    wait_slot("sync_d1", 4'hD);
    bus_write(3'd0, 32'h0000_0000);
    check("dis_seg", 32'(seg_out), 32'h7F);
    check("dis_sel", 32'(digit_sel), 32'hF);
    bus_if.address = 3'd4;
    #1;
    check("dis_status", bus_if.readdata, 32'd0);
    bus_write(3'd0, 32'h0000_0003);
    check("reen_blank_sel", 32'(digit_sel), 32'hF);
    @(negedge clk);
    check("reen_first_sel", 32'(digit_sel), 32'hE);
    check("reen_first_seg", 32'(seg_out), 32'h30);

    // Asynchronous reset mid-slot
    wait_slot("sync_rst", 4'hB);
    bus_if.address = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_sel", 32'(digit_sel), 32'hF);
    check("rst_ctrl", bus_if.readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_sel", 32'(digit_sel), 32'hF);
    read_check("post_rst_hex", 3'd1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
